// File: rtl/cdb_arbiter.sv
// cdb_arbiter -- completion-side transmitter of the common data bus (CDB).
//
// Each functional unit delivers finished results into its own small FIFO.
// Every cycle one non-empty FIFO is chosen round-robin. Its head result is
// loaded into a single registered CDB broadcast. The ROB, reservation
// stations and map table all consume that broadcast.
//
// Optional feature: define CDB_BYPASS_EN to let a unit with an empty FIFO
// and a valid result compete in the same-cycle arbitration with its input
// payload. A winning bypass payload skips the FIFO (1-cycle latency). A
// losing bypass payload is queued as usual. Without the macro, every result
// passes through its FIFO (2-cycle latency).
//
// Ports:
//   clock            in   system clock
//   reset            in   synchronous, active-high reset
//   squash_signal    in   branch-mispredict flush (clears all FIFOs)
//   fu_valid         in   [NUM_FU]        per-unit result valid
//   fu_tag           in   [NUM_FU*TAG_W]  per-unit ROB tag, unit i at [i*TAG_W +: TAG_W]
//   fu_value         in   [NUM_FU*XLEN]   per-unit result value
//   fu_take_branch   in   [NUM_FU]        per-unit branch-taken flag
//   fu_npc           in   [NUM_FU*XLEN]   per-unit next PC
//   fu_ready         out  [NUM_FU]        per-unit FIFO can accept
//   cdb_valid        out  broadcast valid
//   cdb_tag          out  broadcast ROB tag
//   cdb_value        out  broadcast value
//   cdb_take_branch  out  broadcast branch-taken flag
//   cdb_npc          out  broadcast next PC
//
// Handshake: unit i transfers a result on the rising edge of clock where
// fu_valid[i] && fu_ready[i]. fu_ready[i] depends only on registered FIFO
// occupancy and reset. It does not anticipate a pop in the same cycle. A
// unit whose fu_ready is low must hold its result and retry. Results
// offered while squash_signal is high are discarded.

module cdb_arbiter #(
    parameter int NUM_FU     = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int ROB_SIZE   = 32,
    parameter int XLEN       = 32,
    localparam int TAG_W     = $clog2(ROB_SIZE)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     squash_signal,
    input  logic [NUM_FU-1:0]        fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
    input  logic [NUM_FU*XLEN-1:0]   fu_value,
    input  logic [NUM_FU-1:0]        fu_take_branch,
    input  logic [NUM_FU*XLEN-1:0]   fu_npc,
    output logic [NUM_FU-1:0]        fu_ready,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [XLEN-1:0]          cdb_value,
    output logic                     cdb_take_branch,
    output logic [XLEN-1:0]          cdb_npc
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    // Payload layout: {tag, value, take_branch, npc}
    localparam int PAY_W = TAG_W + XLEN + 1 + XLEN;

    logic [PAY_W-1:0] mem    [NUM_FU][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr [NUM_FU];
    logic [PTR_W-1:0] rd_ptr [NUM_FU];
    logic [CNT_W-1:0] count  [NUM_FU];
    logic [IDX_W-1:0] rr_ptr;

    logic [PAY_W-1:0]  in_pay [NUM_FU];
    logic [NUM_FU-1:0] not_empty;
    logic [NUM_FU-1:0] bypass_cand;
    logic [NUM_FU-1:0] candidate;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic              found;
    logic [IDX_W-1:0]  winner;
    logic [IDX_W-1:0]  rr_next;
    logic [PAY_W-1:0]  win_pay;

    // Unpack the flat per-unit buses and derive occupancy and readiness.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            in_pay[i]    = {fu_tag[i*TAG_W +: TAG_W], fu_value[i*XLEN +: XLEN],
                            fu_take_branch[i], fu_npc[i*XLEN +: XLEN]};
            not_empty[i] = (count[i] != '0);
            fu_ready[i]  = !reset && (count[i] != CNT_W'(FIFO_DEPTH));
        end
    end

`ifdef CDB_BYPASS_EN
    // An empty FIFO with a valid input competes using the input payload.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            bypass_cand[i] = !not_empty[i] && fu_valid[i] && !reset && !squash_signal;
        end
    end
`else
    assign bypass_cand = '0;
`endif

    assign candidate = not_empty | bypass_cand;

    // Round-robin search starting at rr_ptr. The first candidate wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NUM_FU;
            if (!found && candidate[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

    assign rr_next = (winner == IDX_W'(NUM_FU - 1)) ? '0 : winner + IDX_W'(1);
    assign win_pay = bypass_cand[winner] ? in_pay[winner] : mem[winner][rd_ptr[winner]];

    // A bypass winner is consumed directly and is not written to its FIFO.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            pop[i]  = found && (winner == IDX_W'(i)) && !bypass_cand[i];
            push[i] = fu_valid[i] && fu_ready[i] && !squash_signal
                      && !(found && (winner == IDX_W'(i)) && bypass_cand[i]);
        end
    end

    // FIFO storage is not reset. Occupancy is tracked only by the counters.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= in_pay[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_FU; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr          <= '0;
            cdb_valid       <= 1'b0;
            cdb_tag         <= '0;
            cdb_value       <= '0;
            cdb_take_branch <= 1'b0;
            cdb_npc         <= '0;
        end else if (squash_signal) begin
            // Flush all queued results. The broadcast fields hold their last value.
            for (int i = 0; i < NUM_FU; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                // FIFO_DEPTH is a power of two, so the pointers wrap naturally.
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
            if (found) begin
                cdb_valid <= 1'b1;
                {cdb_tag, cdb_value, cdb_take_branch, cdb_npc} <= win_pay;
                rr_ptr <= rr_next;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule
